// File: rtl/riscv_load_store_unit.sv
// Load/store sequencer: turns RV32 LB/LH/LW/LBU/LHU/SB/SH/SW into one word-aligned bus
// transaction with byte enables, stalls the core while in flight, and extends load data.
module riscv_load_store_unit #(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Tick,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        rd_we,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        store_q, store_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;

  logic        illegal;
  logic        unaligned;
  logic        accept;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [3:0]  be_raw;
  logic [31:0] wdata_lanes;

  // Request decode on the live inputs; only meaningful when the request is accepted.
  always_comb begin
    illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                (is_store && funct3[2]);
    unaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    accept    = (state_q == StIdle) && start && Tick;
    cnt_inc   = cnt_q + 8'd1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    funct3_d = funct3_q;
    store_d  = store_q;
    mis_d    = mis_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d   = addr;
          wdata_d  = wdata;
          funct3_d = funct3;
          store_d  = is_store;
          mis_d    = illegal || unaligned;
          err_d    = 1'b0;
          cnt_d    = 8'd0;
          state_d  = (illegal || unaligned) ? StErr : StReq;
        end
      end
      StReq: begin
        // Ack wins over the timeout and is taken whether or not Tick is high.
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = StDone;
        end else if (Tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == 8'(TimeoutCycles)) begin
            err_d   = 1'b1;
            state_d = StErr;
          end
        end
      end
      StDone: begin
        cnt_d   = 8'd0;
        state_d = StIdle;
      end
      StErr: begin
        cnt_d   = 8'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      store_q  <= 1'b0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      funct3_q <= funct3_d;
      store_q  <= store_d;
      mis_q    <= mis_d;
      err_q    <= err_d;
    end
  end

  // Bus lane formatting from the latched request.
  always_comb begin
    unique case (funct3_q[1:0])
      2'b00: begin
        be_raw      = 4'b0001 << addr_q[1:0];
        wdata_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_raw      = 4'b0011 << addr_q[1:0];
        wdata_lanes = {2{wdata_q[15:0]}};
      end
      default: begin
        be_raw      = 4'b1111;
        wdata_lanes = wdata_q;
      end
    endcase
  end

  // Load lane select and extension from the captured read word.
  always_comb begin
    unique case (addr_q[1:0])
      2'd0:    byte_sel = rdata_q[7:0];
      2'd1:    byte_sel = rdata_q[15:8];
      2'd2:    byte_sel = rdata_q[23:16];
      default: byte_sel = rdata_q[31:24];
    endcase
    half_sel = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    unique case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = rdata_q;
    endcase
  end

  always_comb begin
    mem_req    = (state_q == StReq);
    busy       = mem_req;
    mem_we     = mem_req && store_q;
    mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_be     = mem_req ? be_raw : 4'd0;
    mem_wdata  = mem_req ? wdata_lanes : 32'd0;
    done       = (state_q == StDone) || (state_q == StErr);
    rd_we      = (state_q == StDone) && !store_q;
    rd_data    = rd_we ? load_ext : 32'd0;
    misaligned = mis_q;
    bus_err    = err_q;
  end

endmodule

// File: tb/tb_riscv_load_store_unit.sv
// Directed bench for the load/store sequencer; expected completions are queued at start
// and checked when the done pulse appears.
module tb_riscv_load_store_unit;

  logic        Clock = 1'b0;
  logic        Reset, Tick, start, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, rd_we, misaligned, bus_err, mem_req, mem_we;
  logic [31:0] rd_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] rd;
    logic        we;
    logic        mis;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   t_start = 0;
  int   last_lat = 0;

  riscv_load_store_unit #(.TimeoutCycles(4)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rd_data(rd_data), .rd_we(rd_we), .misaligned(misaligned), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200us");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done();
    int   n = 0;
    exp_t e;
    while (done !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("done_seen", done, 1);
    last_lat = cyc - t_start;
    if (done === 1'b1) begin
      check("sb_pending", sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rd_data", rd_data, e.rd);
        check("rd_we", rd_we, e.we);
        check("misaligned", misaligned, e.mis);
        check("bus_err", bus_err, e.err);
        check("busy_at_done", busy, 0);
      end
    end
    step();
    check("done_pulse", done, 0);
    check("rd_idle", rd_data, 0);
  endtask

  task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rdat, input int delay,
                     input logic [3:0] be, input logic [31:0] mwd, input logic [31:0] rd,
                     input logic mis);
    exp_t e;
    e.rd  = rd;
    e.we  = !st && !mis;
    e.mis = mis;
    e.err = 1'b0;
    sb.push_back(e);
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    start    = 1'b1;
    t_start  = cyc;
    step();
    start = 1'b0;
    if (!mis) begin
      check("req", mem_req, 1);
      check("busy", busy, 1);
      check("mis_clr", misaligned, 0);
      check("err_clr", bus_err, 0);
      check("mem_addr", mem_addr, {a[31:2], 2'b00});
      check("mem_be", mem_be, be);
      check("mem_we", mem_we, st);
      check("mem_wdata", mem_wdata, mwd);
      // A start raised while busy must not disturb the access in flight.
      for (int i = 0; i < delay; i++) begin
        start = 1'b1;
        addr  = a ^ 32'h40;
        step();
        check("hold_addr", mem_addr, {a[31:2], 2'b00});
        check("hold_be", mem_be, be);
      end
      start     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = rdat;
      step();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end else begin
      check("no_req", mem_req, 0);
      check("mis_set", misaligned, 1);
    end
    wait_done();
  endtask

  initial begin
    exp_t e;
    int   n;
    Reset = 1'b1; Tick = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_we", rd_we, 0);
    check("rst_mis", misaligned, 0);
    check("rst_err", bus_err, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_be", mem_be, 0);
    check("rst_wdata", mem_wdata, 0);
    Reset = 1'b0;

    // Tick low in IDLE: start is not sampled.
    funct3 = 3'b010; addr = 32'h100; start = 1'b1; Tick = 1'b0;
    step();
    check("tick0_busy", busy, 0);
    check("tick0_req", mem_req, 0);
    start = 1'b0; Tick = 1'b1;

    // Loads: word, byte signed/unsigned, half signed/unsigned.
    run(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0);
    check("latency", last_lat, 2);
    run(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 1, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0);
    run(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 0, 4'b1000, 32'h0, 32'h00000080, 1'b0);
    run(1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 0, 4'b1100, 32'h0, 32'hFFFF8001, 1'b0);
    run(1'b0, 3'b101, 32'h100, 32'h0, 32'h1234F00D, 2, 4'b0011, 32'h0, 32'h0000F00D, 1'b0);

    // Stores.
    run(1'b1, 3'b001, 32'h22, 32'h1234ABCD, 32'h5555AAAA, 2, 4'b1100, 32'hABCDABCD, 32'h0,
        1'b0);
    run(1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 0, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0);
    run(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 1, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0);

    // Misaligned and illegal requests never reach the bus.
    run(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 4'b0, 32'h0, 32'h0, 1'b1);
    check("mis_sticky", misaligned, 1);
    check("mis_no_req", mem_req, 0);
    run(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 4'b0, 32'h0, 32'h0, 1'b1);
    run(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 4'b0, 32'h0, 32'h0, 1'b1);
    run(1'b1, 3'b001, 32'h21, 32'h0, 32'h0, 0, 4'b0, 32'h0, 32'h0, 1'b1);
    run(1'b0, 3'b010, 32'h104, 32'h0, 32'h01020304, 0, 4'b1111, 32'h0, 32'h01020304, 1'b0);

    // Timeout: two un-ticked cycles stretch the 4-tick window to 6 cycles.
    e.rd = 32'h0; e.we = 1'b0; e.mis = 1'b0; e.err = 1'b1;
    sb.push_back(e);
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h200; start = 1'b1;
    t_start = cyc;
    step();
    start = 1'b0;
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin
      n++;
      Tick = (n == 2 || n == 3) ? 1'b0 : 1'b1;
      step();
    end
    Tick = 1'b1;
    check("req_cycles", n, 6);
    wait_done();
    mem_ack = 1'b1;
    step();
    check("late_ack_req", mem_req, 0);
    check("late_ack_done", done, 0);
    check("err_sticky", bus_err, 1);
    mem_ack = 1'b0;

    // Reset during REQ with an ack still outstanding.
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h300; start = 1'b1;
    step();
    start = 1'b0;
    check("pre_rst_req", mem_req, 1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rd_we", rd_we, 0);
    check("mid_rst_be", mem_be, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_err", bus_err, 0);
    step();
    check("post_rst_done", done, 0);
    run(1'b0, 3'b010, 32'h304, 32'h0, 32'h13579BDF, 0, 4'b1111, 32'h0, 32'h13579BDF, 1'b0);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
